cross_bar_mem_slave: RTL
========================

// Module: cross_bar_mem_slave
//
// PURPOSE
//   Memory-backed responder for the cross-bar request/ack/resp protocol.
//   Accepts read/write requests from a cross-bar master port and services them
//   from an internal word array. Ack timing is programmable through wait states.
//   Sits on a cross-bar slave port; used as on-chip scratch RAM and as the
//   reference target in cross-bar benches.
//
// PARAMETERS
//   AWIDTH        32            address width (byte address)
//   DWIDTH        32            data width; must be a multiple of 8
//   BASE_ADDR     32'h0000_0000 first byte address decoded by this slave
//   DEPTH         256           number of DWIDTH words; power of 2, >= 2
//   WAIT_STATES   0             extra cycles between request capture and ack (0..15)
//   DEFAULT_RDATA 32'hDEAD_BEEF rdata returned for an out-of-range read
//
// PORTS
//   aclk     in   1       clock; all logic on the rising edge
//   areset   in   1       asynchronous reset, active-high
//   req      in   1       master request; held high until ack is seen
//   addr     in   AWIDTH  byte address; stable while req=1
//   cmd      in   1       0 = read, 1 = write; stable while req=1
//   wdata    in   DWIDTH  write data; stable while req=1
//   ack      out  1       one-cycle pulse: request accepted
//   rdata    out  DWIDTH  read data; valid only while resp=1, else 0
//   resp     out  1       one-cycle pulse on the clock after ack
//
// BEHAVIOUR
//   - Reset: ack=0, resp=0, rdata=0, FSM=IDLE, wait counter=0. Applies
//     immediately (async). Memory contents are not reset and are undefined at
//     power-up.
//   - Address decode:
//     - ADDR_LSB = log2(DWIDTH/8); offset = addr - BASE_ADDR.
//     - In range iff addr >= BASE_ADDR and offset < DEPTH*DWIDTH/8.
//     - Word index = offset[ADDR_LSB +: log2(DEPTH)]. Low ADDR_LSB bits are ignored.
//   - FSM states: IDLE, WAIT, ACK, RESP.
//     - IDLE: on an edge E0 with req=1, latch addr, cmd, wdata and the in-range
//       flag. Next state is ACK if WAIT_STATES=0, else WAIT with cnt=WAIT_STATES-1.
//     - WAIT: decrement cnt each edge. Go to ACK on the edge where cnt==0.
//       The req/addr inputs are not re-sampled here.
//     - ACK: ack=1 for exactly one cycle. At the edge leaving ACK:
//       - Write and in range: mem[idx] <= latched wdata.
//       - Read: rdata <= mem[idx] if in range, else DEFAULT_RDATA.
//       - Write: rdata <= 0.
//       - Then go to RESP. req=1 during this edge is ignored, because the
//         master drops req on the edge after it sees ack.
//     - RESP: resp=1 for one cycle, rdata as above. The next edge clears
//       resp and rdata and returns to IDLE. req is ignored in RESP.
//   - Latency (edges after E0):
//     - ack high after E0+WAIT_STATES.
//     - resp/rdata high after E0+WAIT_STATES+1.
//     - Back-to-back throughput: one transaction per WAIT_STATES+3 cycles.
//   - Read data reflects all writes committed before the read's ACK-exit edge
//     (read-after-write ordering).
//   - Out-of-range write: dropped silently. resp still pulses and rdata=0.
//   - Reset mid-operation: FSM returns to IDLE and outputs clear.
//     - A write commits only on the ACK-exit edge; reset before that edge means
//       no memory change.
//     - A write already committed is kept.
//   - ack and resp are never high in the same cycle.
//   - rdata is 0 whenever resp=0.
//
// TESTING
//   1. WAIT_STATES=0: write 0x0000_0010 <- 0xA5A5_0001, then read 0x10 ->
//      ack 1 cycle after req capture, resp next cycle, rdata=0xA5A5_0001.
//   2. WAIT_STATES=3: read 0x0 after writing 0x1234_5678 -> ack exactly 3
//      cycles later than case 1; resp/rdata one cycle after ack.
//   3. Out of range with DEPTH=256: read 0x0000_0400 -> rdata=0xDEAD_BEEF;
//      write 0x400 <- 0xFFFF_FFFF, then read 0x0 -> mem[0] unchanged.
//   4. Back-to-back: 8 writes at 0x00..0x1C with data i*0x11, then 8 reads ->
//      each read returns i*0x11; req is never acked twice; ack and resp never overlap.
//   5. Assert areset during WAIT of a write to 0x20 (data 0xCAFE_0000) ->
//      ack/resp/rdata go 0 immediately; a later read of 0x20 returns the prior value.
//   6. Unaligned address 0x13 read -> same word as 0x10. req held low
//      for 20 cycles -> ack=resp=0 and rdata=0 throughout.

Source files
------------

// File: rtl/cross_bar_mem_slave_if.sv
// Cross-bar request/ack/resp bus between one master port and one memory slave.
interface cross_bar_mem_slave_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req;
  logic [AWIDTH-1:0] addr;
  logic              cmd;
  logic [DWIDTH-1:0] wdata;
  logic              ack;
  logic [DWIDTH-1:0] rdata;
  logic              resp;

  modport master (output req, addr, cmd, wdata, input ack, rdata, resp);
  modport slave  (input req, addr, cmd, wdata, output ack, rdata, resp);
endinterface

// File: rtl/cross_bar_mem_slave.sv
// Memory-backed cross-bar responder with a programmable number of wait states
// between request capture and ack.
//
// state  | meaning
// S_IDLE | waiting for req; request fields captured on the edge req is seen
// S_WAIT | wait-state countdown, inputs not re-sampled
// S_ACK  | ack pulse; memory write / read data capture on the exit edge
// S_RESP | resp pulse with rdata; both clear on the exit edge
module cross_bar_mem_slave #(
  parameter int                 AWIDTH        = 32,
  parameter int                 DWIDTH        = 32,
  parameter logic [AWIDTH-1:0]  BASE_ADDR     = 32'h0000_0000,
  parameter int                 DEPTH         = 256,
  parameter int                 WAIT_STATES   = 0,
  parameter logic [DWIDTH-1:0]  DEFAULT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  cross_bar_mem_slave_if.slave  bus
);

  localparam int ADDR_LSB = $clog2(DWIDTH / 8);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam longint unsigned SPAN = longint'(DEPTH) * longint'(DWIDTH / 8);
  localparam logic [AWIDTH:0] SPAN_W = (AWIDTH + 1)'(SPAN);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              cmd_q;
  logic              hit_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] offset;
  logic              in_range;

  // Addresses below the base wrap to huge offsets, so both bounds are checked.
  assign offset   = bus.addr - BASE_ADDR;
  assign in_range = (bus.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN_W);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cmd_q     <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      bus.ack   <= 1'b0;
      bus.resp  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            cmd_q   <= bus.cmd;
            hit_q   <= in_range;
            idx_q   <= offset[ADDR_LSB +: IDX_W];
            wdata_q <= bus.wdata;
            if (WAIT_STATES == 0) begin
              state   <= S_ACK;
              bus.ack <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_ACK;
            bus.ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          state    <= S_RESP;
          bus.ack  <= 1'b0;
          bus.resp <= 1'b1;
          if (cmd_q)      bus.rdata <= '0;
          else if (hit_q) bus.rdata <= mem[idx_q];
          else            bus.rdata <= DEFAULT_RDATA;
        end
        S_RESP: begin
          state     <= S_IDLE;
          bus.resp  <= 1'b0;
          bus.rdata <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset forces S_IDLE, so a write interrupted before its ACK-exit edge never lands.
  always_ff @(posedge aclk) begin
    if (state == S_ACK && cmd_q && hit_q) mem[idx_q] <= wdata_q;
  end

endmodule
